// File: rtl/period_averager.sv
// period_averager: measures the clock-cycle spacing between tick_i pulses over
// 2**n consecutive periods (n latched at start, clamped to MAX_PERIODS_LOG2),
// then posts the accumulated sum and the floor average with a one-cycle done_o.
// Aborts with timeout_o if TIMEOUT_CYCLES pass without a tick.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i             begin a measurement (accepted only in IDLE)
//   num_periods_log2_i  log2 of periods to average, latched on accepted start
//   tick_i              single-cycle event pulse
//   busy_o              high while armed or measuring
//   done_o              one-cycle result strobe
//   timeout_o           last measurement was aborted by timeout
//   period_count_o      average period (sum_o >> latched log2)
//   sum_o               sum of measured periods
//   min_period_o, max_period_o  shortest/longest period (PERIOD_MINMAX_EN only)
//
// Optional feature macro: PERIOD_MINMAX_EN
module period_averager #(
  parameter int unsigned COUNT_WIDTH      = 32,
  parameter int unsigned MAX_PERIODS_LOG2 = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 100000000
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic                                        start_i,
  input  logic [$clog2(MAX_PERIODS_LOG2+1)-1:0]       num_periods_log2_i,
  input  logic                                        tick_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic                                        timeout_o,
  output logic [COUNT_WIDTH-1:0]                      period_count_o,
  output logic [COUNT_WIDTH+MAX_PERIODS_LOG2-1:0]     sum_o
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [COUNT_WIDTH-1:0]                      min_period_o,
  output logic [COUNT_WIDTH-1:0]                      max_period_o
`endif
);

  localparam int unsigned LOG2_W = $clog2(MAX_PERIODS_LOG2 + 1);
  localparam int unsigned SUM_W  = COUNT_WIDTH + MAX_PERIODS_LOG2;
  localparam int unsigned PCNT_W = MAX_PERIODS_LOG2 + 1;
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
  logic [SUM_W-1:0]         acc_q, acc_d;
  logic [LOG2_W-1:0]        log2_q, log2_d;
  logic                     busy_d, done_d, timeout_d;
  logic [COUNT_WIDTH-1:0]   avg_d;
  logic [SUM_W-1:0]         sum_d;
  logic [SUM_W-1:0]         total;
  logic [PCNT_W-1:0]        pcnt_inc;
  logic [PCNT_W-1:0]        target;
`ifdef PERIOD_MINMAX_EN
  logic [COUNT_WIDTH-1:0]   run_min_q, run_min_d, run_max_q, run_max_d;
  logic [COUNT_WIDTH-1:0]   min_d, max_d;
  logic [COUNT_WIDTH-1:0]   upd_min, upd_max;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    acc_d     = acc_q;
    log2_d    = log2_q;
    timeout_d = timeout_o;
    avg_d     = period_count_o;
    sum_d     = sum_o;
    // Sum including the period that ends on the current tick
    total     = acc_q + SUM_W'(cnt_q);
    pcnt_inc  = pcnt_q + PCNT_W'(1);
    target    = PCNT_W'(1) << log2_q;
`ifdef PERIOD_MINMAX_EN
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    min_d     = min_period_o;
    max_d     = max_period_o;
    upd_min   = (cnt_q < run_min_q) ? cnt_q : run_min_q;
    upd_max   = (cnt_q > run_max_q) ? cnt_q : run_max_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_ARM;
          log2_d    = (num_periods_log2_i > LOG2_W'(MAX_PERIODS_LOG2)) ?
                      LOG2_W'(MAX_PERIODS_LOG2) : num_periods_log2_i;
          cnt_d     = '0;
          pcnt_d    = '0;
          acc_d     = '0;
          timeout_d = 1'b0;
`ifdef PERIOD_MINMAX_EN
          run_min_d = '1;
          run_max_d = '0;
`endif
        end
      end
      S_ARM, S_MEASURE: begin
        if (tick_i) begin
          cnt_d = COUNT_WIDTH'(1);
          if (state_q == S_ARM) begin
            state_d = S_MEASURE;
          end else begin
            acc_d  = total;
            pcnt_d = pcnt_inc;
`ifdef PERIOD_MINMAX_EN
            run_min_d = upd_min;
            run_max_d = upd_max;
`endif
            if (pcnt_inc == target) begin
              state_d = S_DONE;
              sum_d   = total;
              avg_d   = COUNT_WIDTH'(total >> log2_q);
`ifdef PERIOD_MINMAX_EN
              min_d   = upd_min;
              max_d   = upd_max;
`endif
            end
          end
        end else if (cnt_q == TIMEOUT_VAL) begin
          // No tick for TIMEOUT_CYCLES: abort and post a zero result
          state_d   = S_DONE;
          timeout_d = 1'b1;
          sum_d     = '0;
          avg_d     = '0;
`ifdef PERIOD_MINMAX_EN
          min_d     = '0;
          max_d     = '0;
`endif
        end else begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ARM) || (state_d == S_MEASURE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pcnt_q         <= '0;
      acc_q          <= '0;
      log2_q         <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      period_count_o <= '0;
      sum_o          <= '0;
`ifdef PERIOD_MINMAX_EN
      run_min_q      <= '0;
      run_max_q      <= '0;
      min_period_o   <= '0;
      max_period_o   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pcnt_q         <= pcnt_d;
      acc_q          <= acc_d;
      log2_q         <= log2_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      timeout_o      <= timeout_d;
      period_count_o <= avg_d;
      sum_o          <= sum_d;
`ifdef PERIOD_MINMAX_EN
      run_min_q      <= run_min_d;
      run_max_q      <= run_max_d;
      min_period_o   <= min_d;
      max_period_o   <= max_d;
`endif
    end
  end

endmodule

// File: tb/tb_period_averager.sv
// Directed bench for period_averager (COUNT_WIDTH=16, MAX_PERIODS_LOG2=4,
// TIMEOUT_CYCLES=100). Expected results are queued as stimulus is issued and
// compared by a monitor whenever done_o is seen.
module tb_period_averager;

  localparam int unsigned CW = 16;
  localparam int unsigned ML = 4;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [2:0]    num_periods_log2_i = 3'd0;
  logic          tick_i = 1'b0;
  logic          busy_o, done_o, timeout_o;
  logic [CW-1:0] period_count_o;
  logic [CW+ML-1:0] sum_o;
`ifdef PERIOD_MINMAX_EN
  logic [CW-1:0] min_period_o, max_period_o;
`endif

  period_averager #(
    .COUNT_WIDTH(CW), .MAX_PERIODS_LOG2(ML), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .num_periods_log2_i(num_periods_log2_i), .tick_i(tick_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .period_count_o(period_count_o), .sum_o(sum_o)
`ifdef PERIOD_MINMAX_EN
    , .min_period_o(min_period_o), .max_period_o(max_period_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          to;
    logic [CW+ML-1:0] sum;
    logic [CW-1:0] avg;
    logic [CW-1:0] mn;
    logic [CW-1:0] mx;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard side: compare every posted result against the queued expectation
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      exp_t e;
      done_seen++;
      chk("done_width", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("timeout_o", 32'(timeout_o), 32'(e.to));
        chk("sum_o", 32'(sum_o), 32'(e.sum));
        chk("period_count_o", 32'(period_count_o), 32'(e.avg));
        chk("busy_at_done", 32'(busy_o), 32'd0);
`ifdef PERIOD_MINMAX_EN
        chk("min_period_o", 32'(min_period_o), 32'(e.mn));
        chk("max_period_o", 32'(max_period_o), 32'(e.mx));
`endif
      end
    end
    prev_done = done_o;
  end

  // One sampled clock cycle with the given start/tick levels
  task automatic cyc(input logic st, input logic tk);
    start_i = st;
    tick_i  = tk;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    tick_i  = 1'b0;
  endtask

  // Next tick p cycles after the previous one
  task automatic gap(input int p);
    for (int i = 1; i < p; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
  endtask

  task automatic start_run(input logic [2:0] n);
    num_periods_log2_i = n;
    cyc(1'b1, 1'b0);
    chk("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  // done_o must be up right after the final tick and last exactly one cycle
  task automatic end_run(input string tag);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    cyc(1'b0, 1'b0);
    chk({tag, "_done_clr"}, 32'(done_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (done_o !== 1'b1 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_wait"}, 32'(done_o), 32'd1);
    cyc(1'b0, 1'b0);
  endtask

  task automatic push(input logic to, input int s, input int a, input int mn, input int mx);
    exp_t e;
    e.to = to; e.sum = (CW+ML)'(s); e.avg = CW'(a); e.mn = CW'(mn); e.mx = CW'(mx);
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    chk({tag, "_avg"}, 32'(period_count_o), 32'd0);
    chk({tag, "_sum"}, 32'(sum_o), 32'd0);
`ifdef PERIOD_MINMAX_EN
    chk({tag, "_min"}, 32'(min_period_o), 32'd0);
    chk({tag, "_max"}, 32'(max_period_o), 32'd0);
`endif
  endtask

  initial begin
    int s;
    int sp;
    // 1. reset and idle
    reset_i = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk_zero("reset");
    reset_i = 1'b0;
    repeat (3) cyc(1'b0, 1'b1);
    chk("idle_tick_busy", 32'(busy_o), 32'd0);
    chk("idle_tick_dones", 32'(done_seen), 32'd0);

    // 2. single period
    push(1'b0, 5, 5, 5, 5);
    start_run(3'd0);
    cyc(1'b0, 1'b1);
    gap(5);
    end_run("single");

    // 3. averaging
    push(1'b0, 24, 6, 4, 9);
    start_run(3'd2);
    cyc(1'b0, 1'b1);
    gap(4); gap(6); gap(5); gap(9);
    end_run("avg");
    push(1'b0, 17, 4, 4, 5);
    start_run(3'd2);
    cyc(1'b0, 1'b1);
    gap(4); gap(4); gap(4); gap(5);
    end_run("trunc");

    // 4. timeout in MEASURE: exactly 100 idle cycles after the tick
    push(1'b1, 0, 0, 0, 0);
    start_run(3'd1);
    cyc(1'b0, 1'b1);
    repeat (TO - 1) cyc(1'b0, 1'b0);
    chk("to_not_early", 32'(done_o), 32'd0);
    cyc(1'b0, 1'b0);
    end_run("to_meas");
    chk("timeout_holds", 32'(timeout_o), 32'd1);
    push(1'b0, 11, 5, 3, 8);
    start_run(3'd1);
    chk("timeout_clr", 32'(timeout_o), 32'd0);
    cyc(1'b0, 1'b1);
    gap(3); gap(8);
    end_run("after_to");
    // timeout with no tick at all
    push(1'b1, 0, 0, 0, 0);
    start_run(3'd1);
    wait_done("to_arm", TO + 20);
    // tick on the very cycle the timeout would fire counts as a tick
    push(1'b0, TO, TO, TO, TO);
    start_run(3'd0);
    cyc(1'b0, 1'b1);
    gap(TO);
    end_run("to_edge");

    // 5. reset mid-MEASURE after 2 of 4 periods
    start_run(3'd2);
    cyc(1'b0, 1'b1);
    gap(3); gap(3);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    chk_zero("midreset");
    push(1'b0, 7, 7, 7, 7);
    start_run(3'd0);
    cyc(1'b0, 1'b1);
    gap(7);
    end_run("post_reset");

    // 6a. start while busy is ignored
    push(1'b0, 8, 4, 3, 5);
    start_run(3'd1);
    cyc(1'b0, 1'b1);
    gap(3);
    num_periods_log2_i = 3'd0;
    cyc(1'b1, 1'b0);
    chk("busy_restart", 32'(busy_o), 32'd1);
    gap(4);
    end_run("ign_start");

    // 6b. start and tick together: the tick only arms nothing
    push(1'b0, 6, 6, 6, 6);
    num_periods_log2_i = 3'd0;
    cyc(1'b1, 1'b1);
    gap(2);
    chk("st_tick_busy", 32'(busy_o), 32'd1);
    chk("st_tick_nodone", 32'(done_o), 32'd0);
    gap(6);
    end_run("st_tick");

    // 6c. log2=7 clamps to 16 periods
    s = 0;
    for (int i = 0; i < 16; i++) s += (i % 3) + 2;
    push(1'b0, s, s >> 4, 2, 4);
    start_run(3'd7);
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sp = (i % 3) + 2;
      gap(sp);
      if (i == 14) chk("clamp_not_early", 32'(done_o), 32'd0);
    end
    end_run("clamp");

    repeat (3) cyc(1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
